// File: rtl/div_unit_pkg.sv
// Shared constants and types for the multi-cycle radix-2 divider.
package div_unit_pkg;

    localparam logic [1:0] DIV_ST_IDLE = 2'd0;
    localparam logic [1:0] DIV_ST_CALC = 2'd1;
    localparam logic [1:0] DIV_ST_FIX  = 2'd2;
    localparam int         DIV_STEPS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = DIV_ST_IDLE,
        ST_CALC = DIV_ST_CALC,
        ST_FIX  = DIV_ST_FIX
    } div_state_t;

    function automatic logic [31:0] abs32(
        input logic        neg,
        input logic [31:0] v
    );
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division step on {rem, quo}.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;
    logic           w_neg;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign w_neg   = w_trial[WIDTH];

    assign o_rem = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/div_unit.sv
// 32-bit multi-cycle restoring divider for DIV/DIVU.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    div_state_t       r_state;
    logic             r_sa;
    logic             r_sb;
    logic             r_divz;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_busy;
    logic             r_done;

    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_rem_n;
    logic [WIDTH-1:0] w_quo_n;

    assign w_sa = div_signed & dividend[WIDTH-1];
    assign w_sb = div_signed & divisor[WIDTH-1];

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_quo    (r_quo),
        .i_divisor(r_dvs),
        .o_rem    (w_rem_n),
        .o_quo    (w_quo_n)
    );

    // r_quo starts as |dividend| and is shifted into r_rem bit by bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_divz  <= 1'b0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_divz  <= (divisor == '0);
                        r_dvd   <= dividend;
                        r_dvs   <= abs32(w_sb, divisor);
                        r_quo   <= abs32(w_sa, dividend);
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_n;
                    r_quo <= w_quo_n;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DIV_STEPS - 1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (r_divz) begin
                        r_q <= '1;
                        r_r <= r_dvd;
                    end else begin
                        r_q <= (r_sa ^ r_sb) ? ('0 - r_quo) : r_quo;
                        r_r <= r_sa ? ('0 - r_rem) : r_rem;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign r    = r_r;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit against a 64-bit arithmetic model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_errors;
    logic [31:0] last_q;
    logic [31:0] last_r;

    div_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .div_signed(div_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .q         (q),
        .r         (r),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(
        input  bit          s,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] eq,
        output logic [31:0] er
    );
        longint la;
        longint lb;
        if (b == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = a;
        end else begin
            if (s) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
            end else begin
                la = longint'({32'd0, a});
                lb = longint'({32'd0, b});
            end
            eq = 32'(la / lb);
            er = 32'(la % lb);
        end
    endfunction

    task automatic do_div(
        input string       tag,
        input bit          s,
        input logic [31:0] a,
        input logic [31:0] b,
        input bit          inj,
        input bit          gap
    );
        logic [31:0] eq;
        logic [31:0] er;
        int          lat;
        bit          early;
        model(s, a, b, eq, er);
        lat   = 0;
        early = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        @(posedge clk);
        #1;
        start      = 1'b0;
        dividend   = $urandom;
        divisor    = $urandom;
        div_signed = ~s;
        chk({tag, ".busy_up"}, 32'(busy), 32'd1);
        chk({tag, ".q_hold"}, q, last_q);
        for (int i = 1; i <= 40; i++) begin
            if (inj && i == 10) begin
                start    = 1'b1;
                dividend = 32'd1000;
                divisor  = 32'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) early = 1'b1;
        end
        chk({tag, ".lat"}, 32'(lat), 32'd33);
        chk({tag, ".busy_drop"}, {31'd0, early | busy}, 32'd0);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".r"}, r, er);
        last_q = eq;
        last_r = er;
        if (gap) begin
            @(posedge clk);
            #1;
            chk({tag, ".done_once"}, 32'(done), 32'd0);
            chk({tag, ".q_keep"}, q, eq);
        end
    endtask

    initial begin
        bit          seen;
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        n_checks   = 0;
        n_errors   = 0;
        last_q     = 32'd0;
        last_r     = 32'd0;
        rst        = 1'b1;
        start      = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd55;
        divisor    = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        chk("rst.q", q, 32'd0);
        chk("rst.r", r, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 1'b0, 1'b1);
        do_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        do_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1);
        do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        chk("ovf.q_const", q, 32'h8000_0000);
        do_div("u_ff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1);
        chk("uff.q_const", q, 32'h0FFF_FFFF);
        do_div("u_dz", 1'b0, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
        do_div("s_dz", 1'b1, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
        chk("dz.r_const", r, 32'h1234_5678);
        do_div("inj", 1'b0, 32'd100, 32'd7, 1'b1, 1'b1);
        do_div("b2b_a", 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
        do_div("b2b_b", 1'b0, 32'd9, 32'd3, 1'b0, 1'b1);

        @(negedge clk);
        start      = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rmid.busy", 32'(busy), 32'd0);
        chk("rmid.q", q, 32'd0);
        chk("rmid.r", r, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("rmid.no_done", 32'(seen), 32'd0);
        last_q = 32'd0;
        last_r = 32'd0;
        do_div("u50_5", 1'b0, 32'd50, 32'd5, 1'b0, 1'b1);

        for (int k = 0; k < 30; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 255));
                2: b = 32'd0;
                default: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            endcase
            do_div($sformatf("rnd%0d", k), s, a, b, 1'b0, k[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
- Sits directly downstream of the multi-cycle controller: consumes its div_start/div_signed pulse and returns div_busy, which stalls the controller.
- Quotient feeds LO and remainder feeds HI. The controller latches them on the cycle after busy falls.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported by the controller.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request pulse from the controller (div_start)
- div_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- dividend  in  32  rs value; sampled with start
- divisor  in  32  rt value; sampled with start
- q  out  32  quotient (to LO)
- r  out  32  remainder (to HI)
- busy  out  1  high while a division is in progress (div_busy)
- done  out  1  one-cycle pulse; q/r are valid from this cycle on

Behaviour:
- Reset: on a rising edge with rst=1, state=IDLE and q, r, busy, done, counter, and working registers are all 0. rst has priority over start.
- Reset mid-operation aborts the division. q/r read 0 afterwards, and no done pulse is produced.
- States: IDLE, CALC, FIX.
- IDLE, start=1 sampled at edge E0:
  - latch signs: sa=dividend[31]&div_signed, sb=divisor[31]&div_signed;
  - latch |dividend| and |divisor| (absolute value only when div_signed);
  - latch divz=(divisor==0);
  - clear partial remainder and counter;
  - busy<=1; go to CALC.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Form trial = rem - |divisor| at 33 bits.
  - If trial is non-negative, rem=trial and the quotient LSB is 1; otherwise the quotient LSB is 0.
  - The counter increments each step. After 32 steps (edges E1..E32) go to FIX.
- FIX at edge E33:
  - q = sa^sb ? -quo : quo, and r = sa ? -rem : rem, both wrapping mod 2^32.
  - If divz, force q=0xFFFFFFFF and r=dividend as latched, in either mode.
  - busy<=0, done<=1; return to IDLE.
- Latency:
  - busy is high for exactly 33 cycles (after E0 through E33).
  - done is high for the cycle after E33 only.
- Outputs:
  - q/r keep their value until the next FIX or reset.
  - q/r are not cleared at start. Intermediate values are never exposed on q/r.
- start while busy=1 is ignored: no restart and no operand resample.
- start in the same cycle that done is high is accepted normally (back-to-back).
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives q=0x80000000, r=0. This falls out of the wrapping negate and needs no special case.
- Remainder sign always follows the dividend; the quotient truncates toward zero.

Decomposition:
- Shared constants header, included alongside the INST_TYPE_* encodings: DIV_ST_IDLE/DIV_ST_CALC/DIV_ST_FIX (2-bit) and DIV_STEPS=32.
- One natural sub-module: div_step.
  - Purely combinational.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside the CALC datapath.
- The FSM, sign handling, and divide-by-zero override stay in div_unit.

Test Plan:
- Unsigned: div_signed=0, 100/7.
  - busy rises after E0 and falls after E33.
  - done pulses once.
  - q=14, r=2.
- Signed: 0xFFFFFFF9 (-7) / 2 → q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also 7 / 0xFFFFFFFE (-2) → q=0xFFFFFFFD, r=1.
- Corner cases:
  - 0x80000000 / 0xFFFFFFFF signed → q=0x80000000, r=0.
  - 0xFFFFFFFF / 0x10 unsigned → q=0x0FFFFFFF, r=0xF.
- Divide by zero: 0x12345678 / 0 in both modes → q=0xFFFFFFFF, r=0x12345678, same 33-cycle latency.
- Handshake:
  - A second start pulse at E10 with different operands is ignored; the result is that of the first request.
  - start asserted in the done cycle launches a new division (100/7 followed by 9/3 → q=3, r=0 after another 33 cycles).
- Reset mid-op: rst=1 at E15.
  - Next cycle: busy=0, q=r=0, and done is never seen for the aborted division.
  - A following 50/5 completes with q=10, r=0.
